voting_machine: RTL and testbench
=================================

VOTING_MACHINE -- requirements
Module: voting_machine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk samples everything on its rising edge; rst, when high at a rising edge, resets the block.
REQ-002 Parameter LOCKOUT_CYCLES SHALL default to 2 and SHALL set the post-vote lockout length in cycles; it is used only when VOTE_LOCKOUT_EN is defined.
REQ-003 clk SHALL be an input, 1 bit wide: the system clock.
REQ-004 rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-005 i_candidate_1, i_candidate_2 and i_candidate_3 SHALL each be an input, 1 bit wide: vote button for that candidate, high while pressed.
REQ-006 i_voting_over SHALL be an input, 1 bit wide: closes voting and requests display of results.
REQ-007 o_count1, o_count2 and o_count3 SHALL each be an output, 6 bits wide, registered: displayed tally for candidates 1, 2 and 3.

Function
REQ-008 The block SHALL capture all four control inputs into one input register every cycle; all decisions SHALL use these registered copies only.
REQ-009 The FSM SHALL have exactly three states: S_VOTE (accepting votes), S_HOLD (waiting for button release) and S_OVER (closed, displaying results).
REQ-010 In S_VOTE with exactly one registered button high and registered i_voting_over low, the block SHALL increment that candidate's internal 6-bit tally at the next edge and move to S_HOLD.
REQ-011 In S_VOTE with two or more registered buttons high, the block SHALL count no vote and SHALL move to S_HOLD.
REQ-012 In S_HOLD, the block SHALL return to S_VOTE only after a cycle in which all registered buttons are low, so one press yields at most one vote regardless of its length.
REQ-013 In S_VOTE or S_HOLD, a registered i_voting_over high SHALL move the block to S_OVER; any button press in the same cycle SHALL be discarded.
REQ-014 S_OVER SHALL be left only by rst; buttons and later deassertion of i_voting_over SHALL be ignored there.
REQ-015 Outputs SHALL read 0 in S_VOTE and S_HOLD; from the first edge after entering S_OVER, each o_countN SHALL equal its internal tally.
REQ-016 Each tally SHALL saturate at 63 with no wrap-around; further presses SHALL be consumed (FSM goes to S_HOLD) without changing the tally.
REQ-017 Latency: a button sampled at edge k SHALL update the tally at edge k+1.

Reset
REQ-018 rst SHALL clear all tallies, outputs and the input register to 0 and SHALL force S_VOTE; it SHALL take priority over every other input in any state, including mid-press and in S_OVER.
REQ-019 While rst is high, no vote SHALL be counted.

Configuration
REQ-020 With macro VOTE_LOCKOUT_EN defined, S_HOLD SHALL additionally hold for LOCKOUT_CYCLES cycles after the all-released cycle; presses during the lockout SHALL be ignored and SHALL need a release before they can count.
REQ-021 Without VOTE_LOCKOUT_EN, S_HOLD SHALL exit on the first all-released cycle and LOCKOUT_CYCLES SHALL be unused.

Verification
REQ-022 Basic tally: apply rst for 2 cycles; press the sequence 1, 2, 1, 3, 2, 2, 1, 3, each press 1 cycle high with a 2-cycle gap; assert i_voting_over -> outputs 0 before close, then o_count1=3, o_count2=3, o_count3=2.
REQ-023 Long press and simultaneous press: hold candidate 1 for 10 cycles, then press candidates 2 and 3 together -> after close, o_count1=1, o_count2=0, o_count3=0.
REQ-024 Saturation: press candidate 3 seventy times, then close -> o_count3=63.
REQ-025 Close precedence and freeze: assert a candidate 1 press in the same cycle as i_voting_over, then press candidates and drop i_voting_over -> o_count1 unchanged and outputs held.
REQ-026 Reset: assert rst in S_OVER -> all outputs 0 at the next edge, and a following press counts normally.
REQ-027 VOTE_LOCKOUT_EN: with the macro defined, press candidate 1, release it, and press again in the first post-release cycle -> second press not counted; without the macro it is counted.

Source files
------------

// File: rtl/voting_machine.sv
// rtl/voting_machine.sv - three-candidate voting machine with press debouncing and result display
// Optional post-vote lockout enabled by defining VOTE_LOCKOUT_EN.
module voting_machine #(
  parameter int LOCKOUT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_candidate_1,
  input  logic       i_candidate_2,
  input  logic       i_candidate_3,
  input  logic       i_voting_over,
  output logic [5:0] o_count1,
  output logic [5:0] o_count2,
  output logic [5:0] o_count3
);

  typedef enum logic [1:0] {S_VOTE, S_HOLD, S_OVER} state_t;

  state_t     state, state_next;
  logic       cand1_q, cand2_q, cand3_q, over_q;
  logic [5:0] tally1, tally2, tally3;
  logic       inc1, inc2, inc3;
  logic       any_btn;

`ifdef VOTE_LOCKOUT_EN
  logic        lock_q, lock_next;
  logic [15:0] lock_cnt, lock_cnt_next;
`else
  // Parameter kept for interface compatibility; only the lockout build consumes it.
  logic unused_lockout;
  assign unused_lockout = |LOCKOUT_CYCLES;
`endif

  always_comb begin
    state_next = state;
    inc1       = 1'b0;
    inc2       = 1'b0;
    inc3       = 1'b0;
    any_btn    = cand1_q | cand2_q | cand3_q;
`ifdef VOTE_LOCKOUT_EN
    lock_next     = lock_q;
    lock_cnt_next = lock_cnt;
`endif
    case (state)
      S_VOTE: begin
        if (over_q) begin
          state_next = S_OVER;
        end else if (any_btn) begin
          inc1       = cand1_q & ~cand2_q & ~cand3_q;
          inc2       = ~cand1_q & cand2_q & ~cand3_q;
          inc3       = ~cand1_q & ~cand2_q & cand3_q;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (over_q) begin
          state_next = S_OVER;
`ifdef VOTE_LOCKOUT_EN
        end else if (any_btn) begin
          // A press during lockout must be released again before it can count.
          lock_next = 1'b0;
        end else if (!lock_q) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_next = S_VOTE;
          end else begin
            lock_next     = 1'b1;
            lock_cnt_next = 16'(LOCKOUT_CYCLES - 1);
          end
        end else if (lock_cnt == 16'd0) begin
          lock_next  = 1'b0;
          state_next = S_VOTE;
        end else begin
          lock_cnt_next = lock_cnt - 16'd1;
        end
`else
        end else if (!any_btn) begin
          state_next = S_VOTE;
        end
`endif
      end
      S_OVER:  state_next = S_OVER;
      default: state_next = S_VOTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_VOTE;
      cand1_q  <= 1'b0;
      cand2_q  <= 1'b0;
      cand3_q  <= 1'b0;
      over_q   <= 1'b0;
      tally1   <= 6'd0;
      tally2   <= 6'd0;
      tally3   <= 6'd0;
      o_count1 <= 6'd0;
      o_count2 <= 6'd0;
      o_count3 <= 6'd0;
`ifdef VOTE_LOCKOUT_EN
      lock_q   <= 1'b0;
      lock_cnt <= 16'd0;
`endif
    end else begin
      state   <= state_next;
      cand1_q <= i_candidate_1;
      cand2_q <= i_candidate_2;
      cand3_q <= i_candidate_3;
      over_q  <= i_voting_over;
      // Saturating tallies: a press at 63 is consumed without effect.
      if (inc1 && tally1 != 6'd63) tally1 <= tally1 + 6'd1;
      if (inc2 && tally2 != 6'd63) tally2 <= tally2 + 6'd1;
      if (inc3 && tally3 != 6'd63) tally3 <= tally3 + 6'd1;
      o_count1 <= (state == S_OVER) ? tally1 : 6'd0;
      o_count2 <= (state == S_OVER) ? tally2 : 6'd0;
      o_count3 <= (state == S_OVER) ? tally3 : 6'd0;
`ifdef VOTE_LOCKOUT_EN
      lock_q   <= lock_next;
      lock_cnt <= lock_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_voting_machine.sv
// tb/tb_voting_machine.sv - directed self-checking bench for voting_machine
module tb_voting_machine;

  logic       clk = 1'b0;
  logic       rst;
  logic       c1, c2, c3, over;
  logic [5:0] o_count1, o_count2, o_count3;
  int         checks = 0;
  int         failures = 0;

  voting_machine dut (
    .clk           (clk),
    .rst           (rst),
    .i_candidate_1 (c1),
    .i_candidate_2 (c2),
    .i_candidate_3 (c3),
    .i_voting_over (over),
    .o_count1      (o_count1),
    .o_count2      (o_count2),
    .o_count3      (o_count3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [5:0] e1, input logic [5:0] e2,
                           input logic [5:0] e3);
    check({tag, "_c1"}, o_count1, e1);
    check({tag, "_c2"}, o_count2, e2);
    check({tag, "_c3"}, o_count3, e3);
  endtask

  task automatic press(input logic [2:0] btn, input int len, input int gap);
    {c3, c2, c1} = btn;
    cycles(len);
    {c3, c2, c1} = 3'b000;
    cycles(gap);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    {c3, c2, c1} = 3'b000;
    over = 1'b0;
    cycles(n);
    rst = 1'b0;
  endtask

  // Outputs become valid three edges after i_voting_over is driven.
  task automatic close_vote();
    over = 1'b1;
    cycles(3);
  endtask

  initial begin
    rst = 1'b1;
    {c3, c2, c1} = 3'b000;
    over = 1'b0;
    cycles(2);
    check_all("reset", 6'd0, 6'd0, 6'd0);
    rst = 1'b0;

    // Basic tally: 1,2,1,3,2,2,1,3
    press(3'b001, 1, 4); press(3'b010, 1, 4); press(3'b001, 1, 4); press(3'b100, 1, 4);
    press(3'b010, 1, 4); press(3'b010, 1, 4); press(3'b001, 1, 4); press(3'b100, 1, 4);
    check_all("pre_close", 6'd0, 6'd0, 6'd0);
    close_vote();
    check_all("tally", 6'd3, 6'd3, 6'd2);

    // Long press counts once; simultaneous press counts nothing
    do_reset(2);
    check_all("reset2", 6'd0, 6'd0, 6'd0);
    press(3'b001, 10, 4);
    press(3'b110, 1, 4);
    close_vote();
    check_all("long_multi", 6'd1, 6'd0, 6'd0);

    // Saturation
    do_reset(2);
    for (int i = 0; i < 70; i++) press(3'b100, 1, 4);
    close_vote();
    check_all("saturate", 6'd0, 6'd0, 6'd63);

    // Close wins over a same-cycle press; S_OVER ignores later inputs
    do_reset(2);
    press(3'b001, 1, 4);
    press(3'b001, 1, 4);
    {c3, c2, c1} = 3'b001;
    over = 1'b1;
    cycles(1);
    c1 = 1'b0;
    cycles(3);
    check_all("close_prec", 6'd2, 6'd0, 6'd0);
    press(3'b010, 1, 4);
    press(3'b001, 1, 4);
    over = 1'b0;
    cycles(4);
    press(3'b100, 1, 4);
    check_all("frozen", 6'd2, 6'd0, 6'd0);

    // Reset from S_OVER clears outputs at the next edge, then voting resumes
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_all("over_reset", 6'd0, 6'd0, 6'd0);
    press(3'b010, 1, 4);
    close_vote();
    check_all("after_reset", 6'd0, 6'd1, 6'd0);

    // Presses while rst is high are not counted
    rst = 1'b1;
    over = 1'b0;
    c1 = 1'b1;
    cycles(3);
    c1 = 1'b0;
    rst = 1'b0;
    cycles(3);
    close_vote();
    check_all("rst_press", 6'd0, 6'd0, 6'd0);

    // Re-press in the first post-release cycle
    do_reset(2);
    press(3'b001, 1, 1);
    press(3'b001, 1, 6);
    close_vote();
`ifdef VOTE_LOCKOUT_EN
    check("repress_c1", o_count1, 6'd1);
`else
    check("repress_c1", o_count1, 6'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
